wb_fifo_slave: RTL and testbench

Wishbone responder (slave) for the 8-bit single-master bus: stb, adr, rw (1 = write), dat, ack.
- Exposes a TX byte FIFO (bus writes, drained by a downstream valid/ready stream) and an RX byte FIFO (filled by an upstream strobe, drained by bus reads).
- Also provides status, control, count registers and a level interrupt.
- Sits on the peripheral side of the CPU bus bridge; ack latency is bounded so the master's 16-clock timeout never fires.

---
 rtl/wb_fifo_slave_pkg.sv | 36 +++
 rtl/wb_fifo_slave_if.sv | 20 ++
 rtl/wb_fifo_slave_sync_fifo.sv | 60 ++++++
 rtl/wb_fifo_slave.sv | 188 ++++++++++++++++++
 tb/tb_wb_fifo_slave.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_fifo_slave_pkg.sv
// wb_fifo_slave_pkg: shared constants for the Wishbone FIFO responder.
//   - register offsets (wb_adri[1:0])
//   - STATUS and CTRL bit positions
//   - FSM state encoding
package wb_fifo_slave_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVF   = 5;
    localparam int ST_RX_UDF   = 6;
    localparam int ST_IRQ      = 7;

    // CTRL bit positions; bits 6 and 7 are write-1 strobes that read back 0
    localparam int CT_RX_IRQ_EN  = 0;
    localparam int CT_TX_IRQ_EN  = 1;
    localparam int CT_LOOP_EN    = 2;
    localparam int CT_CLR_STICKY = 6;
    localparam int CT_FLUSH      = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/wb_fifo_slave_if.sv
// wb_fifo_slave_if: 8-bit single-master Wishbone-style bus.
//   wb_stbi  strobe, wb_adri address, wb_rwi (1 = write), wb_dati write data
//   wb_acko  one-cycle acknowledge, wb_dato read data
// Handshake: the master raises wb_stbi with stable adr/rw/dat and holds it
// until it sees wb_acko; the slave pulses wb_acko for exactly one cycle per
// strobe and ignores the strobe until the master drops it again. wb_dato is
// valid in the cycle wb_acko is high (read accesses only).
interface wb_fifo_slave_if;
    logic       wb_stbi;
    logic [7:0] wb_adri;
    logic       wb_rwi;
    logic [7:0] wb_dati;
    logic       wb_acko;
    logic [7:0] wb_dato;

    modport master (output wb_stbi, wb_adri, wb_rwi, wb_dati,
                    input  wb_acko, wb_dato);
    modport slave  (input  wb_stbi, wb_adri, wb_rwi, wb_dati,
                    output wb_acko, wb_dato);
endinterface

// File: rtl/wb_fifo_slave_sync_fifo.sv
// sync_fifo: 8-bit synchronous FIFO with separate occupancy counter.
//   clk, rst     clock, synchronous active-high reset
//   push, din    write request and data (ignored when full unless popping)
//   pop          read request (ignored when empty)
//   flush        empties the FIFO; overrides push and pop
//   head         oldest entry (undefined while empty)
//   full, empty  occupancy flags; count 0..DEPTH
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == 4'd0);
    assign full  = (count == 4'(DEPTH));
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; a pop on an empty FIFO is always a no-op.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone responder exposing a TX and an RX byte FIFO plus
// STATUS, CTRL and COUNT registers and a level interrupt.
//   clk, rst          clock, synchronous active-high reset
//   bus               wb_fifo_slave_if.slave (stb/adr/rw/dat in, ack/dato out)
//   tx_data/valid/ready  TX stream out, transfer on valid & ready
//   rx_data/valid     RX push strobe in, no backpressure
//   irq               registered level interrupt
//   state             current access FSM state (observability)
// Optional feature: define WB_FIFO_SLAVE_LOOPBACK_EN to implement CTRL[2]
// loop_en (TX head is moved into RX; tx_valid forced low, rx_valid ignored).
module wb_fifo_slave
    import wb_fifo_slave_pkg::*;
#(
    parameter logic [3:0] BASE        = 4'h2,
    parameter int         DEPTH       = 8,
    parameter int         WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_fifo_slave_if.slave       bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 irq,
    output state_t               state
);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [3:0] cnt;
    logic [1:0] adr_q;
    logic       rw_q;
    logic [7:0] dat_q;
    logic       acko;
    logic [7:0] dato;
    logic [2:0] ctrl_q;
    logic       tx_ovf, rx_ovf, rx_udf;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [3:0] tx_cnt, rx_cnt;
    logic [7:0] tx_head, rx_head, rx_din;
    logic       tx_push, tx_pop, rx_push, rx_pop;

    logic       hit, go, rd, wr, ctrl_wr, flush, clr;
    logic [1:0] acc_adr;
    logic       acc_rw;
    logic [7:0] acc_dat, status, rd_val;
    logic       unused_adr;

    assign unused_adr = ^bus.wb_adri[3:2];
    assign bus.wb_acko = acko;
    assign bus.wb_dato = dato;

    assign hit = bus.wb_stbi && (bus.wb_adri[7:4] == BASE);

    // go marks the edge that enters ACK; the register side effect happens
    // there. With no wait states that is the sampling edge itself, so the
    // live bus inputs are used instead of the (not yet loaded) latches.
    assign go      = ((state == S_IDLE) && hit && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));
    assign acc_adr = (state == S_IDLE) ? bus.wb_adri[1:0] : adr_q;
    assign acc_rw  = (state == S_IDLE) ? bus.wb_rwi       : rw_q;
    assign acc_dat = (state == S_IDLE) ? bus.wb_dati      : dat_q;

    assign rd      = go & ~acc_rw;
    assign wr      = go & acc_rw;
    assign tx_push = wr & (acc_adr == REG_DATA);
    assign rx_pop  = rd & (acc_adr == REG_DATA);
    assign ctrl_wr = wr & (acc_adr == REG_CTRL);
    assign flush   = ctrl_wr & acc_dat[CT_FLUSH];
    assign clr     = ctrl_wr & acc_dat[CT_CLR_STICKY];

`ifdef WB_FIFO_SLAVE_LOOPBACK_EN
    logic loop_xfer;
    assign loop_xfer = ctrl_q[CT_LOOP_EN] & ~tx_empty & ~rx_full;
    assign tx_valid  = ~tx_empty & ~ctrl_q[CT_LOOP_EN];
    assign tx_pop    = loop_xfer | (tx_valid & tx_ready);
    assign rx_push   = ctrl_q[CT_LOOP_EN] ? loop_xfer : rx_valid;
    assign rx_din    = ctrl_q[CT_LOOP_EN] ? tx_head : rx_data;
`else
    assign tx_valid  = ~tx_empty;
    assign tx_pop    = tx_valid & tx_ready;
    assign rx_push   = rx_valid;
    assign rx_din    = rx_data;
`endif
    assign tx_data = tx_head;

    sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush),
        .din(acc_dat), .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
    );

    sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(flush),
        .din(rx_din), .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
    );

    always_comb begin
        status                = 8'h00;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_OVF]     = tx_ovf;
        status[ST_RX_OVF]     = rx_ovf;
        status[ST_RX_UDF]     = rx_udf;
        status[ST_IRQ]        = irq;
    end

    always_comb begin
        rd_val = 8'h00;
        case (acc_adr)
            REG_DATA:   rd_val = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rd_val = status;
            REG_CTRL:   rd_val = {5'b00000, ctrl_q};
            REG_COUNT:  rd_val = {tx_cnt, rx_cnt};
            default:    rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            adr_q  <= 2'd0;
            rw_q   <= 1'b0;
            dat_q  <= 8'h00;
            acko   <= 1'b0;
            dato   <= 8'h00;
            ctrl_q <= 3'b000;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq <= (ctrl_q[CT_RX_IRQ_EN] & ~rx_empty) | (ctrl_q[CT_TX_IRQ_EN] & tx_empty);

            // A new event in the same cycle as clear-sticky keeps the flag set.
            tx_ovf <= (tx_ovf & ~clr) | (tx_push & tx_full & ~tx_pop);
            rx_ovf <= (rx_ovf & ~clr) | (rx_push & rx_full & ~rx_pop & ~flush);
            rx_udf <= (rx_udf & ~clr) | (rx_pop & rx_empty);

            if (ctrl_wr) begin
                ctrl_q[CT_RX_IRQ_EN] <= acc_dat[CT_RX_IRQ_EN];
                ctrl_q[CT_TX_IRQ_EN] <= acc_dat[CT_TX_IRQ_EN];
`ifdef WB_FIFO_SLAVE_LOOPBACK_EN
                ctrl_q[CT_LOOP_EN]   <= acc_dat[CT_LOOP_EN];
`endif
            end

            case (state)
                S_IDLE: begin
                    if (hit) begin
                        adr_q <= bus.wb_adri[1:0];
                        rw_q  <= bus.wb_rwi;
                        dat_q <= bus.wb_dati;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACK;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WS_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_ACK;
                    else             cnt   <= cnt - 4'd1;
                end
                S_ACK: begin
                    state <= S_DONE;
                    acko  <= 1'b0;
                end
                S_DONE: begin
                    // Wait for the strobe to drop so one strobe yields one ack.
                    if (!bus.wb_stbi) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (go) begin
                acko <= 1'b1;
                if (rd) dato <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_wb_fifo_slave.sv
module tb_wb_fifo_slave;
    import wb_fifo_slave_pkg::*;

    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_fifo_slave_if bus0();
    wb_fifo_slave_if bus1();

    logic [7:0] tx_data0, rx_data0, tx_data1, rx_data1;
    logic       tx_valid0, tx_ready0, rx_valid0, irq0;
    logic       tx_valid1, tx_ready1, rx_valid1, irq1;
    state_t     state0, state1;

    wb_fifo_slave #(.BASE(4'h2), .DEPTH(D), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .irq(irq0), .state(state0)
    );

    wb_fifo_slave #(.BASE(4'h2), .DEPTH(D), .WAIT_STATES(12)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .irq(irq1), .state(state1)
    );

    // scoreboard: bit 8 = compare read data, [7:0] = expected wb_dato
    logic [8:0] exp_q[$];
    logic [8:0] exp1_q[$];
    logic [7:0] tx_exp_q[$];   // bytes the TX stream must emit, in order
    logic [7:0] rx_m[$];       // reference RX FIFO contents
    logic [2:0] ctrl_m;
    logic       tx_ovf_m, rx_ovf_m, rx_udf_m;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_status();
        logic irq_m;
        irq_m = (ctrl_m[0] && rx_m.size() > 0) || (ctrl_m[1] && tx_exp_q.size() == 0);
        return {irq_m, rx_udf_m, rx_ovf_m, tx_ovf_m,
                tx_exp_q.size() == D, tx_exp_q.size() == 0,
                rx_m.size() == D, rx_m.size() == 0};
    endfunction

    function automatic logic [7:0] m_count();
        return {4'(tx_exp_q.size()), 4'(rx_m.size())};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_bus0
        logic [8:0] e;
        if (!rst && bus0.wb_acko) begin
            check("ack0_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e[8]) check("rd0_data", bus0.wb_dato, e[7:0]);
            end
        end
    end

    always @(negedge clk) begin : mon_bus1
        logic [8:0] e;
        if (!rst && bus1.wb_acko) begin
            check("ack1_pending", 32'(exp1_q.size() != 0), 1);
            if (exp1_q.size() != 0) begin
                e = exp1_q.pop_front();
                if (e[8]) check("rd1_data", bus1.wb_dato, e[7:0]);
            end
        end
    end

    always @(negedge clk) begin : mon_tx
        if (!rst && tx_valid0 && tx_ready0) begin
            check("tx_pending", 32'(tx_exp_q.size() != 0), 1);
            if (tx_exp_q.size() != 0) check("tx_data", tx_data0, tx_exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- drivers ----------------
    function automatic logic acko_of(input bit w);
        return w ? bus1.wb_acko : bus0.wb_acko;
    endfunction

    task automatic drive(input bit w, input logic s, input logic [7:0] a, input logic r, input logic [7:0] d);
        if (w) begin
            bus1.wb_stbi = s; bus1.wb_adri = a; bus1.wb_rwi = r; bus1.wb_dati = d;
        end else begin
            bus0.wb_stbi = s; bus0.wb_adri = a; bus0.wb_rwi = r; bus0.wb_dati = d;
        end
    endtask

    // Starts and ends #1 after a rising edge. Latency is counted in rising
    // edges from the cycle the strobe is first presented.
    task automatic bus_op(input bit w, input logic rw, input logic [7:0] adr, input logic [7:0] dat,
                          input int hold, input bit with_rx, input logic [7:0] rxd, input bit exp_ack);
        int lat;
        int i;
        bit got;
        lat = 0; got = 0; i = 0;
        drive(w, 1'b1, adr, rw, dat);
        if (with_rx) begin rx_valid0 = 1'b1; rx_data0 = rxd; end
        while (!got && i < 20) begin
            @(posedge clk); #1;
            i++;
            rx_valid0 = 1'b0;
            if (acko_of(w)) begin got = 1; lat = i; end
        end
        if (exp_ack) check(w ? "ack_latency1" : "ack_latency0", lat, w ? 13 : 1);
        else         check("no_ack", 32'(got), 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_no_second_ack", 32'(acko_of(w)), 0);
        end
        drive(w, 1'b0, adr, rw, dat);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic m_write(input logic [7:0] adr, input logic [7:0] dat);
        case (adr[1:0])
            REG_DATA: begin
                if (ctrl_m[2]) begin
                    if (rx_m.size() < D) rx_m.push_back(dat);
                end else if (tx_exp_q.size() == D) tx_ovf_m = 1'b1;
                else tx_exp_q.push_back(dat);
            end
            REG_CTRL: begin
                ctrl_m[1:0] = dat[1:0];
`ifdef WB_FIFO_SLAVE_LOOPBACK_EN
                ctrl_m[2] = dat[2];
`endif
                if (dat[6]) begin tx_ovf_m = 1'b0; rx_ovf_m = 1'b0; rx_udf_m = 1'b0; end
                if (dat[7]) begin rx_m.delete(); tx_exp_q.delete(); end
            end
            default: ;
        endcase
        exp_q.push_back(9'h000);
        bus_op(1'b0, 1'b1, adr, dat, 0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic m_read(input logic [7:0] adr, input int hold, input bit with_rx, input logic [7:0] rxd);
        logic [7:0] e;
        e = 8'h00;
        case (adr[1:0])
            REG_DATA: begin
                if (rx_m.size() == 0) rx_udf_m = 1'b1;
                else e = rx_m.pop_front();
            end
            REG_STATUS: e = m_status();
            REG_CTRL:   e = {5'b00000, ctrl_m};
            default:    e = m_count();
        endcase
        if (with_rx) begin
            if (rx_m.size() < D) rx_m.push_back(rxd);
            else rx_ovf_m = 1'b1;
        end
        exp_q.push_back({1'b1, e});
        bus_op(1'b0, 1'b0, adr, 8'h00, hold, with_rx, rxd, 1'b1);
    endtask

    task automatic rx_push(input logic [7:0] d);
        if (rx_m.size() < D) rx_m.push_back(d);
        else rx_ovf_m = 1'b1;
        rx_valid0 = 1'b1; rx_data0 = d;
        @(posedge clk); #1;
        rx_valid0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int k);
        tx_ready0 = 1'b1;
        repeat (k) @(posedge clk);
        #1 tx_ready0 = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        tx_ready0 = 0; rx_valid0 = 0; rx_data0 = 0;
        tx_ready1 = 0; rx_valid1 = 0; rx_data1 = 0;
        ctrl_m = 3'b000; tx_ovf_m = 0; rx_ovf_m = 0; rx_udf_m = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ack0", 32'(bus0.wb_acko), 0);
        check("rst_dato0", bus0.wb_dato, 8'h00);
        check("rst_irq0", 32'(irq0), 0);
        check("rst_tx_valid0", 32'(tx_valid0), 0);
        check("rst_state0", state0, S_IDLE);
        check("rst_ack1", 32'(bus1.wb_acko), 0);
        @(posedge clk); #1;

        // single TX write, COUNT, drain
        m_write(8'h20, 8'hA5);
        check("tx_valid_after_wr", 32'(tx_valid0), 1);
        check("tx_data_after_wr", tx_data0, 8'hA5);
        m_read(8'h23, 0, 0, 0);
        m_read(8'h21, 0, 0, 0);
        drain(2);
        check("tx_valid_drained", 32'(tx_valid0), 0);

        // RX reads, underflow, clear sticky
        rx_push(8'h11);
        rx_push(8'h22);
        m_read(8'h20, 0, 0, 0);
        m_read(8'h20, 0, 0, 0);
        m_read(8'h20, 0, 0, 0);
        m_read(8'h21, 0, 0, 0);
        m_write(8'h22, 8'h40);
        m_read(8'h21, 0, 0, 0);

        // TX overflow, then ordered drain
        for (int i = 0; i < 9; i++) m_write(8'h20, 8'(8'h30 + i));
        m_read(8'h21, 0, 0, 0);
        m_read(8'h23, 0, 0, 0);
        drain(10);
        check("tx_valid_after_burst", 32'(tx_valid0), 0);
        m_write(8'h22, 8'h40);

        // strobe held after ack
        m_read(8'h21, 5, 0, 0);

        // full RX with concurrent push and read
        for (int i = 0; i < D; i++) rx_push(8'(8'h40 + i));
        m_read(8'h20, 0, 1, 8'h99);
        m_read(8'h23, 0, 0, 0);
        m_read(8'h21, 0, 0, 0);
        for (int i = 0; i < D + 1; i++) m_read(8'h20, 0, 0, 0);

        // interrupt
        m_write(8'h22, 8'h01);
        check("irq_rx_empty", 32'(irq0), 0);
        rx_m.push_back(8'h77);
        rx_valid0 = 1'b1; rx_data0 = 8'h77;
        @(posedge clk); #1;
        rx_valid0 = 1'b0;
        check("irq_lag", 32'(irq0), 0);
        @(posedge clk); #1;
        check("irq_set", 32'(irq0), 1);
        m_read(8'h21, 0, 0, 0);
        m_read(8'h20, 0, 0, 0);
        m_read(8'h22, 0, 0, 0);
        m_write(8'h22, 8'h00);

`ifdef WB_FIFO_SLAVE_LOOPBACK_EN
        m_write(8'h22, 8'h04);
        m_write(8'h20, 8'h5A);
        check("loop_tx_valid_a", 32'(tx_valid0), 0);
        m_read(8'h20, 0, 0, 0);
        check("loop_tx_valid_b", 32'(tx_valid0), 0);
        m_write(8'h22, 8'h00);
`endif

        // unmapped base on the zero-wait instance
        bus_op(1'b0, 1'b0, 8'h30, 8'h00, 0, 1'b0, 8'h00, 1'b0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
                0, 1: rx_push(8'($urandom_range(0, 255)));
                2, 3: m_write(8'h20, 8'($urandom_range(0, 255)));
                4, 5: m_read(8'h20, 0, 0, 0);
                6:    m_read(8'(8'h20 + $urandom_range(1, 3)), 0, 0, 0);
                7:    m_write(8'h22, {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0),
                                      4'b0000, 2'($urandom_range(0, 3))});
                8:    drain($urandom_range(1, 4));
                default: m_write(8'($urandom_range(0, 1) ? 8'h21 : 8'h23), 8'($urandom_range(0, 255)));
            endcase
        end
        drain(D + 2);
        check("final_tx_valid", 32'(tx_valid0), 0);
        check("final_exp_q_empty", 32'(exp_q.size()), 0);

        // 12 wait states: latency and unmapped base
        exp1_q.push_back({1'b1, 8'h05});
        bus_op(1'b1, 1'b0, 8'h21, 8'h00, 0, 1'b0, 8'h00, 1'b1);
        bus_op(1'b1, 1'b0, 8'h30, 8'h00, 0, 1'b0, 8'h00, 1'b0);

        // reset in the middle of a waited access
        drive(1'b1, 1'b1, 8'h21, 1'b0, 8'h00);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_state1", state1, S_IDLE);
        check("midrst_ack1", 32'(bus1.wb_acko), 0);
        drive(1'b1, 1'b0, 8'h21, 1'b0, 8'h00);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("final_exp1_q_empty", 32'(exp1_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
